// File: rtl/fill_sequencer.sv
// Pill-bottling sequencer: BCD pill/bottle counters, hopper-starvation and
// bottle-switch timers, and the run/switch/done/error/fatal state machine.
module fill_sequencer #(
    parameter int unsigned TICKS_PER_SEC    = 1000,
    parameter int unsigned HOPPER_TIMEOUT_S = 5,
    parameter int unsigned SWITCH_TIME_S    = 2,
    parameter int unsigned BEEP_TICKS       = 1000
) (
    input  logic        clk_1khz,
    input  logic        clr,
    input  logic        start,
    input  logic        ack,
    input  logic        estop,
    input  logic        pill_pulse,
    input  logic        conveyor_ok,
    input  logic [11:0] tgt_pills,
    input  logic [7:0]  tgt_bottles,
    output logic [11:0] now_pills,
    output logic [7:0]  now_bottles,
    output logic [2:0]  state,
    output logic        err_cause,
    output logic        hopper_gate,
    output logic        conveyor_run,
    output logic        run_beep
);

    localparam int unsigned HopLoad = HOPPER_TIMEOUT_S * TICKS_PER_SEC;
    localparam int unsigned SwLoad  = SWITCH_TIME_S * TICKS_PER_SEC;
    localparam int unsigned HopW    = $clog2(HopLoad + 1);
    localparam int unsigned SwW     = $clog2(SwLoad + 1);
    localparam int unsigned BeepW   = $clog2(BEEP_TICKS + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StSwitch = 3'd2,
        StDone   = 3'd3,
        StError  = 3'd4,
        StFatal  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [11:0]        now_pills_q, now_pills_d;
    logic [7:0]         now_bottles_q, now_bottles_d;
    logic [11:0]        tgt_pills_q, tgt_pills_d;
    logic [7:0]         tgt_bottles_q, tgt_bottles_d;
    logic               err_cause_q, err_cause_d;
    logic [HopW-1:0]    hop_tmr_q, hop_tmr_d;
    logic [SwW-1:0]     sw_tmr_q, sw_tmr_d;
    logic [BeepW-1:0]   beep_q, beep_d;
    logic               hopper_gate_q, hopper_gate_d;
    logic               conveyor_run_q, conveyor_run_d;

    // Three-digit BCD increment with ripple carry.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        cy;
        r  = v;
        cy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cy) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    cy          = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Nonzero and every nibble a legal BCD digit.
    function automatic logic bcd_valid(input logic [11:0] v);
        logic ok;
        ok = (v != 12'h000);
        for (int i = 0; i < 3; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [11:0] pills_inc;
    logic [11:0] bottles_inc_w;
    logic [7:0]  bottles_inc;
    logic        bottle_full;
    state_e      pill_next;

    // Outcome of counting one pill from the current counters.
    always_comb begin
        pills_inc     = bcd_inc(now_pills_q);
        bottles_inc_w = bcd_inc({4'h0, now_bottles_q});
        bottles_inc   = bottles_inc_w[7:0];
        bottle_full   = (pills_inc == tgt_pills_q);
        pill_next     = StRun;
        if (bottle_full) begin
            pill_next = (bottles_inc == tgt_bottles_q) ? StDone : StSwitch;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        now_pills_d   = now_pills_q;
        now_bottles_d = now_bottles_q;
        tgt_pills_d   = tgt_pills_q;
        tgt_bottles_d = tgt_bottles_q;
        err_cause_d   = err_cause_q;
        hop_tmr_d     = hop_tmr_q;
        sw_tmr_d      = sw_tmr_q;
        beep_d        = (beep_q == '0) ? '0 : beep_q - 1'b1;

        if (estop) begin
            state_d = StFatal;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && bcd_valid(tgt_pills) && bcd_valid({4'h0, tgt_bottles})) begin
                        tgt_pills_d   = tgt_pills;
                        tgt_bottles_d = tgt_bottles;
                        now_pills_d   = 12'h000;
                        now_bottles_d = 8'h00;
                        state_d       = StRun;
                    end
                end
                StRun: begin
                    if (pill_pulse) begin
                        now_pills_d = pills_inc;
                        hop_tmr_d   = HopW'(HopLoad);
                        if (bottle_full) now_bottles_d = bottles_inc;
                        state_d = pill_next;
                        if (pill_next == StSwitch) sw_tmr_d = SwW'(SwLoad);
                    end else begin
                        hop_tmr_d = hop_tmr_q - 1'b1;
                        if (hop_tmr_q <= HopW'(1)) begin
                            hop_tmr_d   = '0;
                            state_d     = StError;
                            err_cause_d = 1'b0;
                        end
                    end
                end
                StSwitch: begin
                    if (pill_pulse) begin
                        state_d = StFatal;
                    end else begin
                        sw_tmr_d = sw_tmr_q - 1'b1;
                        if (sw_tmr_q <= SwW'(1)) begin
                            sw_tmr_d = '0;
                            if (conveyor_ok) begin
                                now_pills_d = 12'h000;
                                state_d     = StRun;
                            end else begin
                                state_d     = StError;
                                err_cause_d = 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    if (ack) state_d = StIdle;
                end
                StError: begin
                    if (!err_cause_q) begin
                        // A late pill is counted as if we were still running.
                        if (pill_pulse) begin
                            now_pills_d = pills_inc;
                            if (bottle_full) now_bottles_d = bottles_inc;
                            state_d = pill_next;
                            if (pill_next == StSwitch) sw_tmr_d = SwW'(SwLoad);
                        end
                    end else if (pill_pulse) begin
                        state_d = StFatal;
                    end else if (conveyor_ok) begin
                        now_pills_d = 12'h000;
                        state_d     = StRun;
                    end
                end
                StFatal: begin
                    if (ack) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // Any entry into RUNNING rearms the starvation timer and the beep.
        if (state_d == StRun && state_q != StRun) begin
            hop_tmr_d = HopW'(HopLoad);
            beep_d    = BeepW'(BEEP_TICKS);
        end

        hopper_gate_d  = (state_d == StRun) || (state_d == StError && !err_cause_d);
        conveyor_run_d = (state_d == StSwitch);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            state_q        <= StIdle;
            now_pills_q    <= '0;
            now_bottles_q  <= '0;
            tgt_pills_q    <= '0;
            tgt_bottles_q  <= '0;
            err_cause_q    <= 1'b0;
            hop_tmr_q      <= '0;
            sw_tmr_q       <= '0;
            beep_q         <= '0;
            hopper_gate_q  <= 1'b0;
            conveyor_run_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            now_pills_q    <= now_pills_d;
            now_bottles_q  <= now_bottles_d;
            tgt_pills_q    <= tgt_pills_d;
            tgt_bottles_q  <= tgt_bottles_d;
            err_cause_q    <= err_cause_d;
            hop_tmr_q      <= hop_tmr_d;
            sw_tmr_q       <= sw_tmr_d;
            beep_q         <= beep_d;
            hopper_gate_q  <= hopper_gate_d;
            conveyor_run_q <= conveyor_run_d;
        end
    end

    assign state        = state_q;
    assign now_pills    = now_pills_q;
    assign now_bottles  = now_bottles_q;
    assign err_cause    = err_cause_q;
    assign hopper_gate  = hopper_gate_q;
    assign conveyor_run = conveyor_run_q;
    assign run_beep     = (beep_q != '0);

endmodule
